// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver with 16x oversampling.
// The baud divider, parity mode and stop-bit count are captured when a start
// edge is seen, so they may change freely while a frame is being received.
// Each bit is the majority vote of three samples taken around the bit centre.
module uart_rx_cfg #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [15:0]       Baud_Div,
  input  logic [1:0]        Parity_Mode,
  input  logic              Stop2,
  input  logic              uart_rx,
  output logic [DATA_W-1:0] Data,
  output logic              Rx_Done,
  output logic              Parity_Err,
  output logic              Frame_Err,
  output logic              Busy
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP1  = 3'd4,
    ST_STOP2  = 3'd5
  } state_t;

  localparam logic [3:0] BITS_L = 4'(DATA_W);

  // Majority of three samples.
  function automatic logic maj3_f(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Expected parity bit: XOR of data for even, its inverse for odd.
  function automatic logic parity_exp_f(input logic [DATA_W-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   rx_prev_r;
  logic                   rx_s;
  logic                   fall_s;

  state_t                 state_r;
  state_t                 state_nxt_s;

  logic [15:0]            div_cnt_r;
  logic [15:0]            baud_lat_r;
  logic [3:0]             samp_cnt_r;
  logic                   tick_s;
  logic                   samp9_s;
  logic                   wrap_s;
  logic                   s7_r;
  logic                   s8_r;
  logic                   maj_s;

  logic [3:0]             bit_cnt_r;
  logic [DATA_W-1:0]      shift_r;
  logic                   par_en_r;
  logic                   par_odd_r;
  logic                   stop2_lat_r;
  logic                   par_flag_r;
  logic                   frame_flag_r;

  logic                   start_s;
  logic                   shift_en_s;
  logic                   par_chk_s;
  logic                   stop_chk_s;
  logic                   finish_s;

  logic [DATA_W-1:0]      data_r;
  logic                   rx_done_r;
  logic                   par_err_r;
  logic                   frame_err_r;
  logic                   busy_r;

  assign rx_s    = sync_r[SYNC_STAGES-1];
  assign fall_s  = rx_prev_r & ~rx_s;
  assign tick_s  = (state_r != ST_IDLE) && (div_cnt_r == baud_lat_r);
  assign samp9_s = tick_s && (samp_cnt_r == 4'd9);
  assign wrap_s  = tick_s && (samp_cnt_r == 4'd15);
  assign maj_s   = maj3_f(s7_r, s8_r, rx_s);

  assign Data       = data_r;
  assign Rx_Done    = rx_done_r;
  assign Parity_Err = par_err_r;
  assign Frame_Err  = frame_err_r;
  assign Busy       = busy_r;

  // Synchronise the serial line and keep its previous value for edge detect.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync_r    <= {SYNC_STAGES{1'b1}};
      rx_prev_r <= 1'b1;
    end else begin
      sync_r    <= {sync_r[SYNC_STAGES-2:0], uart_rx};
      rx_prev_r <= rx_s;
    end
  end

  // State register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; a frame ends at the centre of its last stop bit.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (fall_s) state_nxt_s = ST_START;
        else        state_nxt_s = ST_IDLE;
      end
      ST_START: begin
        if (samp9_s && maj_s) state_nxt_s = ST_IDLE;
        else if (wrap_s)      state_nxt_s = ST_DATA;
        else                  state_nxt_s = ST_START;
      end
      ST_DATA: begin
        if (wrap_s && (bit_cnt_r == BITS_L)) begin
          if (par_en_r) state_nxt_s = ST_PARITY;
          else          state_nxt_s = ST_STOP1;
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (wrap_s) state_nxt_s = ST_STOP1;
        else        state_nxt_s = ST_PARITY;
      end
      ST_STOP1: begin
        if (samp9_s && !stop2_lat_r) state_nxt_s = ST_IDLE;
        else if (wrap_s)             state_nxt_s = ST_STOP2;
        else                         state_nxt_s = ST_STOP1;
      end
      ST_STOP2: begin
        if (samp9_s) state_nxt_s = ST_IDLE;
        else         state_nxt_s = ST_STOP2;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Per-state strobes driving the datapath.
  always_comb begin
    start_s    = 1'b0;
    shift_en_s = 1'b0;
    par_chk_s  = 1'b0;
    stop_chk_s = 1'b0;
    finish_s   = 1'b0;
    case (state_r)
      ST_IDLE:   start_s    = fall_s;
      ST_START:  start_s    = 1'b0;
      ST_DATA:   shift_en_s = samp9_s;
      ST_PARITY: par_chk_s  = samp9_s;
      ST_STOP1: begin
        stop_chk_s = samp9_s;
        finish_s   = samp9_s && !stop2_lat_r;
      end
      ST_STOP2: begin
        stop_chk_s = samp9_s;
        finish_s   = samp9_s;
      end
      default: start_s = 1'b0;
    endcase
  end

  // Baud tick divider and 16x sample counter, both parked at zero in IDLE.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      div_cnt_r  <= 16'd0;
      samp_cnt_r <= 4'd0;
    end else if (state_r == ST_IDLE) begin
      div_cnt_r  <= 16'd0;
      samp_cnt_r <= 4'd0;
    end else if (tick_s) begin
      div_cnt_r  <= 16'd0;
      samp_cnt_r <= samp_cnt_r + 4'd1;
    end else begin
      div_cnt_r  <= div_cnt_r + 16'd1;
    end
  end

  // Capture the first two of the three majority samples.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s7_r <= 1'b1;
      s8_r <= 1'b1;
    end else begin
      if (tick_s && (samp_cnt_r == 4'd7)) s7_r <= rx_s;
      if (tick_s && (samp_cnt_r == 4'd8)) s8_r <= rx_s;
    end
  end

  // Capture frame configuration at the start edge.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      baud_lat_r  <= 16'd0;
      par_en_r    <= 1'b0;
      par_odd_r   <= 1'b0;
      stop2_lat_r <= 1'b0;
    end else if (start_s) begin
      baud_lat_r  <= Baud_Div;
      par_en_r    <= (Parity_Mode == 2'd1) || (Parity_Mode == 2'd2);
      par_odd_r   <= (Parity_Mode == 2'd2);
      stop2_lat_r <= Stop2;
    end
  end

  // Data shift register, bit counter and sticky error flags for this frame.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      shift_r      <= {DATA_W{1'b0}};
      bit_cnt_r    <= 4'd0;
      par_flag_r   <= 1'b0;
      frame_flag_r <= 1'b0;
    end else if (start_s) begin
      bit_cnt_r    <= 4'd0;
      par_flag_r   <= 1'b0;
      frame_flag_r <= 1'b0;
    end else begin
      if (shift_en_s) begin
        shift_r   <= {maj_s, shift_r[DATA_W-1:1]};
        bit_cnt_r <= bit_cnt_r + 4'd1;
      end
      if (par_chk_s && (maj_s != parity_exp_f(shift_r, par_odd_r))) begin
        par_flag_r <= 1'b1;
      end
      if (stop_chk_s && !maj_s) begin
        frame_flag_r <= 1'b1;
      end
    end
  end

  // Registered outputs; results and Rx_Done appear together on finish.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      data_r      <= {DATA_W{1'b0}};
      rx_done_r   <= 1'b0;
      par_err_r   <= 1'b0;
      frame_err_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      rx_done_r <= finish_s;
      busy_r    <= (state_nxt_s != ST_IDLE);
      if (finish_s) begin
        data_r      <= shift_r;
        par_err_r   <= par_flag_r;
        frame_err_r <= frame_flag_r | ~maj_s;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Testbench for uart_rx_cfg: directed table, hand-written corner sequences
// and randomized frames checked against a frame-level reference model.
module tb_uart_rx_cfg;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [15:0] Baud_Div;
  logic [1:0]  Parity_Mode;
  logic        Stop2;
  logic        rx8;
  logic        rx7;

  logic [7:0]  data8;
  logic        done8, pe8, fe8, busy8;
  logic [6:0]  data7;
  logic        done7, pe7, fe7, busy7;

  int n_tests = 0;
  int n_fail  = 0;
  int busy_cnt8 = 0;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } rec_t;

  rec_t q8[$];
  rec_t q7[$];

  typedef struct {
    int         baud;
    logic [1:0] mode;
    logic       s2;
    logic [7:0] d;
    logic       pbit;
    logic       st1;
    logic       st2;
    logic       scr;
    logic [7:0] exp_d;
    logic       exp_pe;
    logic       exp_fe;
  } vec_t;

  vec_t vecs[8];

  always #5 Clk = ~Clk;

  uart_rx_cfg #(.DATA_W(8), .SYNC_STAGES(2)) dut8 (
    .Clk(Clk), .Reset_n(Reset_n), .Baud_Div(Baud_Div), .Parity_Mode(Parity_Mode),
    .Stop2(Stop2), .uart_rx(rx8), .Data(data8), .Rx_Done(done8),
    .Parity_Err(pe8), .Frame_Err(fe8), .Busy(busy8)
  );

  uart_rx_cfg #(.DATA_W(7), .SYNC_STAGES(3)) dut7 (
    .Clk(Clk), .Reset_n(Reset_n), .Baud_Div(Baud_Div), .Parity_Mode(Parity_Mode),
    .Stop2(Stop2), .uart_rx(rx7), .Data(data7), .Rx_Done(done7),
    .Parity_Err(pe7), .Frame_Err(fe7), .Busy(busy7)
  );

  // Record every completion cycle with the outputs seen in that same cycle.
  always @(negedge Clk) begin
    if (done8) q8.push_back(rec_t'{d: data8, pe: pe8, fe: fe8});
    if (done7) q7.push_back(rec_t'{d: {1'b0, data7}, pe: pe7, fe: fe7});
    if (busy8) busy_cnt8 <= busy_cnt8 + 1;
  end

  // Hard time limit so the run always ends.
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_line(input int which, input logic v);
    if (which == 7) rx7 = v;
    else            rx8 = v;
  endtask

  task automatic drive_bit(input int which, input logic v, input int per);
    set_line(which, v);
    repeat (per) @(negedge Clk);
  endtask

  // Send one frame LSB first; optionally scramble the config once the start bit is out.
  task automatic send_frame(input int which, input int baud, input logic [1:0] mode,
                            input logic s2, input logic [7:0] d, input int nbits,
                            input logic pbit, input logic st1, input logic st2,
                            input logic scr, input int gap_bits);
    int per;
    per = 16 * (baud + 1);
    Baud_Div    = 16'(baud);
    Parity_Mode = mode;
    Stop2       = s2;
    drive_bit(which, 1'b0, per);
    if (scr) begin
      Baud_Div    = 16'($urandom_range(0, 40));
      Parity_Mode = ~mode;
      Stop2       = ~s2;
    end
    for (int i = 0; i < nbits; i++) drive_bit(which, d[i], per);
    if ((mode == 2'd1) || (mode == 2'd2)) drive_bit(which, pbit, per);
    drive_bit(which, st1, per);
    if (s2) drive_bit(which, st2, per);
    set_line(which, 1'b1);
    Baud_Div    = 16'(baud);
    Parity_Mode = mode;
    Stop2       = s2;
    repeat (gap_bits * per) @(negedge Clk);
  endtask

  // Reference: correct parity bit from the count of ones.
  function automatic logic good_pbit(input logic [1:0] mode, input logic [7:0] d);
    int ones;
    ones = $countones(d);
    if (mode == 2'd2) return (ones % 2 == 0);
    else              return (ones % 2 == 1);
  endfunction

  // Reference: parity error only when a parity bit is expected and it is wrong.
  function automatic logic model_pe(input logic [1:0] mode, input logic [7:0] d, input logic pbit);
    if ((mode == 2'd1) || (mode == 2'd2)) return pbit != good_pbit(mode, d);
    else                                  return 1'b0;
  endfunction

  function automatic int qsz(input int which);
    if (which == 7) return q7.size();
    else            return q8.size();
  endfunction

  task automatic expect_frame(input int which, input string tag, input logic [7:0] ed,
                              input logic epe, input logic efe);
    int   waited;
    rec_t r;
    waited = 0;
    while ((qsz(which) == 0) && (waited < 4000)) begin
      @(negedge Clk);
      waited++;
    end
    chk({tag, " rx_done"}, int'(qsz(which) > 0), 1);
    if (qsz(which) > 0) begin
      if (which == 7) r = q7.pop_front();
      else            r = q8.pop_front();
      chk({tag, " data"},       int'(r.d),  int'(ed));
      chk({tag, " parity_err"}, int'(r.pe), int'(epe));
      chk({tag, " frame_err"},  int'(r.fe), int'(efe));
    end
  endtask

  initial begin
    logic [7:0] last_d;
    logic       last_pe;
    logic       last_fe;
    int         bc;

    //            baud mode  s2    data   pbit  st1   st2   scr   exp_d  pe    fe
    vecs[0] = '{26, 2'd0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{26, 2'd1, 1'b0, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0};
    vecs[2] = '{26, 2'd0, 1'b0, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0, 8'h55, 1'b0, 1'b1};
    vecs[3] = '{ 3, 2'd2, 1'b1, 8'h80, 1'b0, 1'b1, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0};
    vecs[4] = '{ 3, 2'd3, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0};
    vecs[5] = '{ 0, 2'd1, 1'b0, 8'h01, 1'b1, 1'b1, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[6] = '{ 0, 2'd2, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[7] = '{ 2, 2'd1, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b1, 1'b0, 8'hC3, 1'b0, 1'b1};

    Reset_n     = 1'b0;
    Baud_Div    = 16'd26;
    Parity_Mode = 2'd0;
    Stop2       = 1'b0;
    rx8         = 1'b1;
    rx7         = 1'b1;
    repeat (3) @(negedge Clk);

    chk("reset data8",   int'(data8), 0);
    chk("reset done8",   int'(done8), 0);
    chk("reset perr8",   int'(pe8),   0);
    chk("reset ferr8",   int'(fe8),   0);
    chk("reset busy8",   int'(busy8), 0);
    chk("reset data7",   int'(data7), 0);
    chk("reset busy7",   int'(busy7), 0);

    Reset_n = 1'b1;
    repeat (5) @(negedge Clk);

    // Directed table.
    for (int i = 0; i < 8; i++) begin
      send_frame(8, vecs[i].baud, vecs[i].mode, vecs[i].s2, vecs[i].d, 8, vecs[i].pbit,
                 vecs[i].st1, vecs[i].st2, vecs[i].scr, 2);
      expect_frame(8, $sformatf("vec%0d", i), vecs[i].exp_d, vecs[i].exp_pe, vecs[i].exp_fe);
      chk($sformatf("vec%0d single pulse", i), qsz(8), 0);
      chk($sformatf("vec%0d busy idle", i), int'(busy8), 0);
    end
    last_d  = vecs[7].exp_d;
    last_pe = vecs[7].exp_pe;
    last_fe = vecs[7].exp_fe;

    // False start: low for 20 clocks at Baud_Div=3.
    bc          = busy_cnt8;
    Baud_Div    = 16'd3;
    Parity_Mode = 2'd0;
    Stop2       = 1'b0;
    rx8 = 1'b0;
    repeat (20) @(negedge Clk);
    rx8 = 1'b1;
    repeat (200) @(negedge Clk);
    chk("false start busy rose",  int'(busy_cnt8 > bc), 1);
    chk("false start busy fell",  int'(busy8), 0);
    chk("false start no rx_done", qsz(8), 0);
    chk("false start data held",  int'(data8), int'(last_d));
    chk("false start perr held",  int'(pe8), int'(last_pe));
    chk("false start ferr held",  int'(fe8), int'(last_fe));

    // Randomized frames against the reference model.
    for (int i = 0; i < 20; i++) begin
      int         baud;
      logic [1:0] mode;
      logic       s2, pbit, st1, st2, scr;
      logic [7:0] d;
      baud = $urandom_range(0, 3);
      mode = 2'($urandom_range(0, 3));
      s2   = 1'($urandom_range(0, 1));
      d    = 8'($urandom);
      pbit = ($urandom_range(0, 3) == 0) ? ~good_pbit(mode, d) : good_pbit(mode, d);
      st1  = ($urandom_range(0, 4) != 0);
      st2  = ($urandom_range(0, 4) != 0);
      scr  = 1'($urandom_range(0, 1));
      send_frame(8, baud, mode, s2, d, 8, pbit, st1, st2, scr, 2);
      expect_frame(8, $sformatf("rand%0d", i), d, model_pe(mode, d, pbit), !st1 || (s2 && !st2));
      chk($sformatf("rand%0d single pulse", i), qsz(8), 0);
    end

    // Seven data bits, odd parity, two stop bits, two frames back to back.
    send_frame(7, 3, 2'd2, 1'b1, 8'h12, 7, good_pbit(2'd2, 8'h12), 1'b1, 1'b1, 1'b0, 0);
    send_frame(7, 3, 2'd2, 1'b1, 8'h6F, 7, good_pbit(2'd2, 8'h6F), 1'b1, 1'b1, 1'b0, 2);
    expect_frame(7, "w7 first",  8'h12, 1'b0, 1'b0);
    expect_frame(7, "w7 second", 8'h6F, 1'b0, 1'b0);
    chk("w7 pulse count", qsz(7), 0);

    // Reset during data bit 3 of a frame, then a clean frame.
    Baud_Div    = 16'd3;
    Parity_Mode = 2'd0;
    Stop2       = 1'b0;
    drive_bit(8, 1'b0, 64);
    drive_bit(8, 1'b0, 64);
    drive_bit(8, 1'b1, 64);
    drive_bit(8, 1'b0, 64);
    drive_bit(8, 1'b1, 32);
    Reset_n = 1'b0;
    #1;
    chk("mid reset data",  int'(data8), 0);
    chk("mid reset busy",  int'(busy8), 0);
    chk("mid reset done",  int'(done8), 0);
    rx8 = 1'b1;
    repeat (10) @(negedge Clk);
    Reset_n = 1'b1;
    repeat (100) @(negedge Clk);
    chk("aborted frame no rx_done", qsz(8), 0);
    send_frame(8, 3, 2'd0, 1'b0, 8'hC3, 8, 1'b0, 1'b1, 1'b1, 1'b0, 2);
    expect_frame(8, "after reset", 8'hC3, 1'b0, 1'b0);
    chk("after reset single pulse", qsz(8), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
